// File: rtl/learn_clip_pkg.sv
// Shared widths and float field layout for the learn_clip dst datapath.
// A lane travels as split {sign, exp, man} fields and is repacked into one IEEE-754 single word.
package learn_clip_pkg;

    localparam int LANES  = 8;
    localparam int MAN_W  = 23;
    localparam int EXP_W  = 8;
    localparam int FP_W   = 1 + EXP_W + MAN_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int VEC_W  = LANES * FP_W;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_fields_t;

    // Bit-exact concatenation: no rounding or normalisation is applied.
    function automatic logic [FP_W-1:0] fp_pack(input fp_fields_t f);
        return {f.sign, f.exp, f.man};
    endfunction

endpackage

// File: rtl/learn_clip_dst_collector_if.sv
// Word stream leaving the collector: valid/ready with lane tag and end-of-vector marker.
interface learn_clip_dst_collector_if;
    import learn_clip_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   out_data;
    logic [LANE_W-1:0] out_lane;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_lane,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_lane,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/learn_clip_vec_fifo.sv
// Whole-vector FIFO: one entry holds all lanes, written in a single cycle.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module learn_clip_vec_fifo
    import learn_clip_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [VEC_W-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [VEC_W-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [VEC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define validity.
    // On full-with-pop the write lands in the slot being read out this same cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/learn_clip_dst_collector.sv
// Receiving end of the learn_clip dst interface: packs each lane into a float word, buffers
// whole vectors and serialises them one word per beat. Dropped vectors raise a sticky flag.
module learn_clip_dst_collector
    import learn_clip_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic                       dst_valid,
    input  logic [LANES*MAN_W-1:0]     dst_man,
    input  logic [LANES*EXP_W-1:0]     dst_exp,
    input  logic [LANES-1:0]           dst_sign,
    learn_clip_dst_collector_if.master out_if,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    logic [VEC_W-1:0]  wr_vec;
    logic [VEC_W-1:0]  rd_vec;
    logic [FP_W-1:0]   rd_lanes [LANES];
    fp_fields_t        lane_fields [LANES];

    logic              fifo_full;
    logic              fifo_empty;
    logic              beat_accept;
    logic              pop_vec;
    logic              capture;
    logic              drop;

    logic [LANE_W-1:0] lane_cnt_reg;
    logic [LANE_W-1:0] lane_cnt_next;
    logic              overflow_reg;
    logic              overflow_next;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_fields[gi].sign = dst_sign[gi];
            assign lane_fields[gi].exp  = dst_exp[gi*EXP_W +: EXP_W];
            assign lane_fields[gi].man  = dst_man[gi*MAN_W +: MAN_W];
            assign wr_vec[gi*FP_W +: FP_W] = fp_pack(lane_fields[gi]);
            assign rd_lanes[gi] = rd_vec[gi*FP_W +: FP_W];
        end
    endgenerate

    assign beat_accept = out_if.out_valid && out_if.out_ready;
    assign pop_vec     = beat_accept && out_if.out_last;
    // A vector leaving this cycle frees its slot, so a full buffer can still accept.
    assign capture     = enable && dst_valid && (!fifo_full || pop_vec);
    assign drop        = enable && dst_valid && fifo_full && !pop_vec;

    learn_clip_vec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (capture),
        .wr_data (wr_vec),
        .rd_en   (pop_vec),
        .rd_data (rd_vec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        lane_cnt_next = lane_cnt_reg;
        if (beat_accept) begin
            if (lane_cnt_reg == LAST_LANE) begin
                lane_cnt_next = '0;
            end else begin
                lane_cnt_next = lane_cnt_reg + LANE_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            lane_cnt_reg <= lane_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

    // lane_cnt only advances on accepted beats, so the word holds steady while stalled.
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = rd_lanes[lane_cnt_reg];
    assign out_if.out_lane  = lane_cnt_reg;
    assign out_if.out_last  = (lane_cnt_reg == LAST_LANE);
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_learn_clip_dst_collector.sv
// Bench for learn_clip_dst_collector: directed scenarios plus random traffic, checked every
// cycle against a queue-of-vectors model of the collector.
module tb_learn_clip_dst_collector;
    import learn_clip_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rstn;
    logic                   enable;
    logic                   dst_valid;
    logic [LANES*MAN_W-1:0] dst_man;
    logic [LANES*EXP_W-1:0] dst_exp;
    logic [LANES-1:0]       dst_sign;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   ovf_clr;
    logic [VEC_W-1:0]       cur_vec;

    learn_clip_dst_collector_if bus ();

    learn_clip_dst_collector #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .dst_valid (dst_valid),
        .dst_man   (dst_man),
        .dst_exp   (dst_exp),
        .dst_sign  (dst_sign),
        .out_if    (bus),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bench holds vectors as packed words; split them into the fields learn_clip drives.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_drv
            assign dst_sign[gi]                = cur_vec[gi*FP_W + FP_W - 1];
            assign dst_exp[gi*EXP_W +: EXP_W]  = cur_vec[gi*FP_W + MAN_W +: EXP_W];
            assign dst_man[gi*MAN_W +: MAN_W]  = cur_vec[gi*FP_W +: MAN_W];
        end
    endgenerate

    // Model: list of buffered vectors, current lane within the head vector, sticky flag.
    logic [VEC_W-1:0] mq[$];
    int               m_lane;
    bit               m_ovf;
    int               checks;
    int               errors;
    int               vec_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic compare();
        bit mv;
        mv = (mq.size() > 0);
        check("out_valid", 64'(bus.out_valid), 64'(mv));
        check("level", 64'(level), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("out_lane", 64'(bus.out_lane), 64'(m_lane));
        check("out_last", 64'(bus.out_last), 64'(m_lane == LANES - 1));
        if (mv) begin
            logic [VEC_W-1:0] head;
            head = mq[0];
            check("out_data", 64'(bus.out_data), 64'(head[m_lane*FP_W +: FP_W]));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, then compare.
    task automatic tick(input bit v, input bit r, input bit e, input bit c);
        bit mv, pop, cap, drop;
        dst_valid     = v;
        bus.out_ready = r;
        enable        = e;
        ovf_clr       = c;
        mv   = (mq.size() > 0);
        pop  = mv && r && (m_lane == LANES - 1);
        cap  = e && v && ((mq.size() < DEPTH) || pop);
        drop = e && v && (mq.size() == DEPTH) && !pop;
        if (mv && r) begin
            logic [VEC_W-1:0] head;
            head = mq[0];
            $display("beat lane=%0d data=%08h last=%0d", m_lane, head[m_lane*FP_W +: FP_W],
                     (m_lane == LANES - 1));
            if (m_lane == LANES - 1) begin
                void'(mq.pop_front());
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        if (cap) begin
            mq.push_back(cur_vec);
            $display("capture vec=%0d level=%0d", vec_id, mq.size());
        end
        if (drop) begin
            m_ovf = 1'b1;
            $display("drop vec=%0d", vec_id);
        end else if (c) begin
            m_ovf = 1'b0;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic new_vec_random();
        vec_id++;
        for (int i = 0; i < LANES; i++) begin
            cur_vec[i*FP_W +: FP_W] = $urandom();
        end
    endtask

    task automatic new_vec_tagged();
        vec_id++;
        for (int i = 0; i < LANES; i++) begin
            cur_vec[i*FP_W +: FP_W] = {1'b0, 8'(vec_id), 15'(i), 8'h5A};
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        vec_id        = 0;
        m_lane        = 0;
        m_ovf         = 1'b0;
        rstn          = 1'b0;
        enable        = 1'b0;
        dst_valid     = 1'b0;
        ovf_clr       = 1'b0;
        bus.out_ready = 1'b0;
        cur_vec       = '0;
        #1;
        compare();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        compare();

        // 1: single vector, lane i = {0, 7F, i}
        vec_id++;
        for (int i = 0; i < LANES; i++) begin
            cur_vec[i*FP_W +: FP_W] = {1'b0, 8'h7F, 23'(i)};
        end
        tick(1, 1, 1, 0);
        for (int i = 0; i < LANES; i++) begin
            check("t1_data_literal", 64'(bus.out_data), 64'(32'h3F80_0000 + i));
            check("t1_lane_literal", 64'(bus.out_lane), 64'(i));
            tick(0, 1, 1, 0);
        end
        check("t1_empty_after", 64'(bus.out_valid), 64'd0);

        // 2: random backpressure, lane i sign = i[0]
        for (int n = 0; n < 3; n++) begin
            new_vec_random();
            for (int i = 0; i < LANES; i++) begin
                cur_vec[i*FP_W + FP_W - 1] = i[0];
            end
            tick(1, 1'($urandom_range(0, 1)), 1, 0);
            for (int k = 0; k < 14; k++) begin
                tick(0, 1'($urandom_range(0, 1)), 1, 0);
            end
        end
        for (int k = 0; k < 40; k++) tick(0, 1, 1, 0);

        // 3: fill and overflow
        for (int n = 0; n < 5; n++) begin
            new_vec_tagged();
            tick(1, 0, 1, 0);
        end
        check("t3_level_full", 64'(level), 64'd4);
        check("t3_overflow_set", 64'(overflow), 64'd1);
        for (int k = 0; k < 4 * LANES; k++) tick(0, 1, 1, 0);
        tick(0, 0, 1, 1);
        check("t3_overflow_clr", 64'(overflow), 64'd0);

        // 4: full buffer with capture on the out_last handshake
        for (int n = 0; n < 4; n++) begin
            new_vec_tagged();
            tick(1, 0, 1, 0);
        end
        for (int k = 0; k < LANES - 1; k++) tick(0, 1, 1, 0);
        new_vec_tagged();
        tick(1, 1, 1, 0);
        check("t4_level_held", 64'(level), 64'd4);
        check("t4_no_overflow", 64'(overflow), 64'd0);
        for (int k = 0; k < 4 * LANES; k++) tick(0, 1, 1, 0);

        // 5: streaming one vector per LANES cycles
        for (int n = 0; n < 4; n++) begin
            new_vec_random();
            tick(1, 1, 1, 0);
            check("t5_valid", 64'(bus.out_valid), 64'd1);
            for (int k = 0; k < LANES - 1; k++) begin
                tick(0, 1, 1, 0);
                check("t5_valid", 64'(bus.out_valid), 64'd1);
                check("t5_level_le1", 64'(level <= 1), 64'd1);
            end
        end
        tick(0, 1, 1, 0);

        // 6: reset at beat 3 of vector 2
        for (int n = 0; n < 2; n++) begin
            new_vec_tagged();
            tick(1, 0, 1, 0);
        end
        for (int k = 0; k < LANES + 3; k++) tick(0, 1, 1, 0);
        check("t6_pre_lane", 64'(bus.out_lane), 64'd3);
        dst_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        mq.delete();
        m_lane = 0;
        m_ovf  = 1'b0;
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_level", 64'(level), 64'd0);
        compare();
        @(negedge clk);
        rstn = 1'b1;
        new_vec_tagged();
        tick(1, 0, 1, 0);
        check("t6_restart_lane", 64'(bus.out_lane), 64'd0);
        for (int k = 0; k < LANES + 2; k++) tick(0, 1, 1, 0);

        // random mixed traffic including enable=0 and ovf_clr
        for (int k = 0; k < 400; k++) begin
            new_vec_random();
            tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < 5 * LANES; k++) tick(0, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
